// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer: radix-2 restoring division,
// one quotient bit per cycle, with early completion for divide-by-zero and signed overflow.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            sel_rem_q, sel_rem_d;

  logic            accept;
  logic            is_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, overflow;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] q_final, r_final, final_res;

  always_comb begin
    accept    = (state_q == IDLE) && start && funct3[2] && !flush;
    is_signed = !funct3[0];
    a_neg     = is_signed && op_a[XLEN-1];
    b_neg     = is_signed && op_b[XLEN-1];
    a_mag     = a_neg ? ('0 - op_a) : op_a;
    b_mag     = b_neg ? ('0 - op_b) : op_b;
    div_zero  = (op_b == '0);
    overflow  = is_signed && (op_a == MIN_NEG) && (op_b == '1);
    // Partial remainder gets the dividend MSB; one extra bit keeps the borrow.
    shifted   = {rem_q, quo_q[XLEN-1]};
    trial     = shifted - {1'b0, dvs_q};
    q_final   = q_neg_q ? ('0 - quo_q) : quo_q;
    r_final   = r_neg_q ? ('0 - rem_q) : rem_q;
    final_res = sel_rem_q ? r_final : q_final;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    sel_rem_d = sel_rem_q;
    stall     = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    result    = result_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          sel_rem_d = funct3[1];
          cnt_d     = CW'(XLEN - 1);
          if (div_zero) begin
            quo_d   = '1;
            rem_d   = op_a;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = DONE;
          end else if (overflow) begin
            quo_d   = MIN_NEG;
            rem_d   = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == '0) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
          done     = 1'b1;
          result   = final_res;
          result_d = final_res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      sel_rem_q <= sel_rem_d;
    end
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle controller for the RV32M divide/remainder operations (DIV, DIVU, REM, REMU), sitting in the execute stage beside the single-cycle ALU.
- Accepts one operation from the decoded instruction stream.
- Runs a radix-2 restoring division, one quotient bit per cycle.
- Stalls the pipeline until the result is ready, then presents the result for exactly one cycle.
- Special-case operands complete early without iterating.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  core clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  execute-stage instruction is a divide op; sampled only in IDLE.
funct3  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; start ignored if funct3[2]=0.
op_a  input  XLEN  dividend, sampled at accept.
op_b  input  XLEN  divisor, sampled at accept.
flush  input  1  pipeline kill; aborts the current operation.
stall  output  1  hold the front of the pipeline.
busy  output  1  FSM not in IDLE.
done  output  1  one-cycle pulse; result valid.
result  output  XLEN  quotient or remainder.

Behaviour:
Reset:
- rst_n low forces state IDLE immediately.
- Iteration counter, quotient, remainder and result registers all go to 0.
- Outputs stall=0, busy=0, done=0, result=0.

States: IDLE, CALC, DONE.

Accept:
- Occurs in IDLE when start=1, funct3[2]=1 and flush=0.
- Latch op_a, op_b, funct3.
- Signed ops (funct3[0]=0) divide magnitudes: |op_a|, |op_b|.
- Record sign flags:
  - quotient negative = a_sign XOR b_sign.
  - remainder negative = a_sign.

Special cases (detected at accept):
- Divide by zero (op_b=0): quotient=all ones, remainder=op_a. Go directly to DONE.
- Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): quotient=0x80000000, remainder=0. Go directly to DONE.

Normal path:
- Go to CALC with counter=XLEN-1.
- Each CALC cycle: shift remainder left, bring in the next dividend bit, trial-subtract the divisor. If the trial is non-negative, keep it and set the quotient bit to 1.
- Counter decrements every cycle. When the counter reaches 0, go to DONE on the next edge.
- Trial subtraction is XLEN+1 bits wide to avoid overflow.

DONE:
- Apply sign correction (two's-complement negate of the flagged values).
- Select quotient (funct3[1]=0) or remainder (funct3[1]=1) into the result register.
- done=1 for this single cycle; return to IDLE on the next edge.

Timing (accept at edge of cycle T):
- Normal path: CALC spans T+1..T+32, done=1 in T+33, IDLE in T+34.
- Special case: done=1 in T+1.

stall (combinational):
- 1 when (IDLE && start && funct3[2] && !flush) or state==CALC.
- 0 in DONE, so the instruction retires with the result in the same cycle.

Other rules:
- busy = state!=IDLE.
- result holds its last value after DONE until the next DONE.
- start in CALC or DONE is ignored. The issuing instruction leaves EX in DONE, so start high in DONE is never a new op.
- flush in CALC or DONE: next state IDLE, no done pulse, result unchanged. stall drops in the flush cycle.
- flush together with start in IDLE: no accept.
- rst_n low mid-operation: immediate abort. The first op after reset release runs normally.

Test Plan:
1. DIVU op_a=100, op_b=7, start at T -> stall=1 T..T+32, done=1 and result=14 at T+33, busy=0 at T+34.
2. REM op_a=0xFFFFFFF9 (-7), op_b=2 -> result=0xFFFFFFFF (-1) at T+33. Same operands with DIV -> 0xFFFFFFFD (-3).
3. DIV op_a=5, op_b=0 -> done at T+1, result=0xFFFFFFFF. REMU same operands -> result=5 at T+1.
4. DIV op_a=0x80000000, op_b=0xFFFFFFFF -> result=0x80000000 at T+1. REM same operands -> result=0.
5. DIVU 1000/3, flush=1 at T+10 -> IDLE at T+11, stall=0, no done, result keeps its prior value. A new DIVU 9/3 at T+12 -> result=3 at T+45.
6. rst_n low at T+5 of an op -> busy/stall/done/result=0 immediately. start held high across reset release is accepted at the first clock edge after release.
